bpsk_tx_sequencer: RTL and testbench

Per-sample scheduler for the BPSK transmit chain. It sequences the sine/modulator datapath, the AWGN generator and channel, and the SPI DAC handshake, and paces all of them to a fixed sample rate. It also counts samples per symbol and requests the next data bit at each symbol boundary. It sits between the debounced start button and the datapath blocks, replacing ad-hoc enable wiring with one owned schedule.

---
 rtl/bpsk_tx_pkg.sv | 35 +++
 rtl/bpsk_tx_sequencer_sample_tick_gen.sv | 42 ++++
 rtl/bpsk_tx_sequencer.sv | 136 +++++++++++++
 tb/tb_bpsk_tx_sequencer.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bpsk_tx_pkg.sv
// Shared types, widths and the DAC sample conversion for the BPSK transmit sequencer.
// BPSK_SEQ_SAT_EN selects 16-bit saturation of the channel sample instead of wrapping truncation.
package bpsk_tx_pkg;

    localparam int unsigned SAMPLE_W = 16;
    localparam int unsigned CHAN_W   = 17;

    localparam logic signed [CHAN_W-1:0] SAT_MAX = 17'sd32767;
    localparam logic signed [CHAN_W-1:0] SAT_MIN = -17'sd32768;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_TICK,
        SINE,
        NOISE,
        LOAD,
        DAC_WAIT
    } seq_state_t;

    // Channel sample to DAC code.
    function automatic logic [SAMPLE_W-1:0] to_dac(input logic signed [CHAN_W-1:0] s);
`ifdef BPSK_SEQ_SAT_EN
        if (s > SAT_MAX) begin
            return SAT_MAX[SAMPLE_W-1:0];
        end
        if (s < SAT_MIN) begin
            return SAT_MIN[SAMPLE_W-1:0];
        end
        return s[SAMPLE_W-1:0];
`else
        return s[SAMPLE_W-1:0];
`endif
    endfunction

endpackage

// File: rtl/bpsk_tx_sequencer_sample_tick_gen.sv
// Sample-rate divider with a single-entry pending tick and sticky overrun flag.
module sample_tick_gen #(
    parameter int unsigned SAMPLE_DIV = 25
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic consume,
    output logic pending,
    output logic overrun
);

    localparam int unsigned DIV_W = $clog2(SAMPLE_DIV);

    logic [DIV_W-1:0] div_cnt;
    logic             tick;

    assign tick = (div_cnt == DIV_W'(SAMPLE_DIV - 1));

    // A tick landing on an already-pending, unconsumed slot is an overrun.
    always_ff @(posedge clk) begin
        if (rst) begin
            div_cnt <= '0;
            pending <= 1'b0;
            overrun <= 1'b0;
        end else if (!run) begin
            div_cnt <= '0;
            pending <= 1'b0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + DIV_W'(1);
            if (tick) begin
                pending <= 1'b1;
                if (pending && !consume) begin
                    overrun <= 1'b1;
                end
            end else if (consume) begin
                pending <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/bpsk_tx_sequencer.sv
// Per-sample scheduler for the BPSK transmit chain: sine, AWGN, DAC handshake and symbol pacing.
// BPSK_SEQ_SAT_EN (see bpsk_tx_pkg) enables saturation of the DAC sample.
module bpsk_tx_sequencer
    import bpsk_tx_pkg::*;
#(
    parameter int unsigned SAMPLE_DIV      = 25,
    parameter int unsigned SAMPLES_PER_BIT = 16,
    parameter int unsigned DAC_TIMEOUT     = 255
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       sine_rdy,
    input  logic                       davdac,
    input  logic signed [CHAN_W-1:0]   sample_in,
    output logic                       sine_clk_en,
    output logic                       mod_en,
    output logic                       en_awgn,
    output logic                       awgn_nrst,
    output logic                       dacdav,
    output logic [SAMPLE_W-1:0]        dacdata,
    output logic                       bit_req,
    output logic                       busy,
    output logic                       overrun,
    output logic                       timeout_err
);

    localparam int unsigned SPB_W = $clog2(SAMPLES_PER_BIT);
    localparam int unsigned DAC_W = $clog2(DAC_TIMEOUT + 1);

    seq_state_t       state;
    logic [SPB_W-1:0] sample_cnt;
    logic [DAC_W-1:0] dac_cnt;
    logic             active;
    logic             pending;
    logic             run;
    logic             consume;

    assign run       = (state != IDLE);
    assign consume   = (state == WAIT_TICK) && pending;
    assign mod_en    = active;
    assign busy      = active;
    assign awgn_nrst = active;

    sample_tick_gen #(
        .SAMPLE_DIV(SAMPLE_DIV)
    ) u_tick (
        .clk    (clk),
        .rst    (rst),
        .run    (run),
        .consume(consume),
        .pending(pending),
        .overrun(overrun)
    );

    // Outputs are registered alongside the state they belong to.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            sample_cnt  <= '0;
            dac_cnt     <= '0;
            active      <= 1'b0;
            sine_clk_en <= 1'b0;
            en_awgn     <= 1'b0;
            dacdav      <= 1'b0;
            dacdata     <= '0;
            bit_req     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            sine_clk_en <= 1'b0;
            en_awgn     <= 1'b0;
            bit_req     <= 1'b0;
            case (state)
                IDLE: begin
                    sample_cnt <= '0;
                    if (start) begin
                        state  <= WAIT_TICK;
                        active <= 1'b1;
                    end
                end
                WAIT_TICK: begin
                    // Stop only on a symbol boundary.
                    if (pending) begin
                        if (!start && (sample_cnt == '0)) begin
                            state  <= IDLE;
                            active <= 1'b0;
                        end else begin
                            state       <= SINE;
                            sine_clk_en <= 1'b1;
                        end
                    end
                end
                SINE: begin
                    if (sine_rdy) begin
                        state   <= NOISE;
                        en_awgn <= 1'b1;
                    end
                end
                NOISE: begin
                    state <= LOAD;
                end
                LOAD: begin
                    state   <= DAC_WAIT;
                    dacdata <= to_dac(sample_in);
                    dacdav  <= 1'b1;
                    dac_cnt <= '0;
                end
                DAC_WAIT: begin
                    if (davdac) begin
                        state  <= WAIT_TICK;
                        dacdav <= 1'b0;
                        if (sample_cnt == SPB_W'(SAMPLES_PER_BIT - 1)) begin
                            sample_cnt <= '0;
                            bit_req    <= 1'b1;
                        end else begin
                            sample_cnt <= sample_cnt + SPB_W'(1);
                        end
                    end else if (dac_cnt == DAC_W'(DAC_TIMEOUT - 1)) begin
                        state       <= IDLE;
                        dacdav      <= 1'b0;
                        active      <= 1'b0;
                        timeout_err <= 1'b1;
                    end else begin
                        dac_cnt <= dac_cnt + DAC_W'(1);
                    end
                end
                default: begin
                    state  <= IDLE;
                    active <= 1'b0;
                    dacdav <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bpsk_tx_sequencer.sv
// Directed bench for bpsk_tx_sequencer with a DAC responder model and assertion-based checks.
module tb_bpsk_tx_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        sine_rdy;
    logic        davdac = 1'b0;
    logic [16:0] sample_in;
    logic        sine_clk_en;
    logic        mod_en;
    logic        en_awgn;
    logic        awgn_nrst;
    logic        dacdav;
    logic [15:0] dacdata;
    logic        bit_req;
    logic        busy;
    logic        overrun;
    logic        timeout_err;

    int checks = 0;
    int errors = 0;

    int cyc = 0;
    int dav_rises = 0;
    int bitreq_cnt = 0;
    int last_rise = 0;
    int prev_rise = 0;
    int dcnt = 0;
    logic dav_q = 1'b0;
    logic dac_on = 1'b1;
    int dac_delay = 3;

    bpsk_tx_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .sine_rdy   (sine_rdy),
        .davdac     (davdac),
        .sample_in  (sample_in),
        .sine_clk_en(sine_clk_en),
        .mod_en     (mod_en),
        .en_awgn    (en_awgn),
        .awgn_nrst  (awgn_nrst),
        .dacdav     (dacdav),
        .dacdata    (dacdata),
        .bit_req    (bit_req),
        .busy       (busy),
        .overrun    (overrun),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    // Output monitor and DAC: davdac pulses dac_delay cycles after dacdav rises.
    always @(negedge clk) begin
        cyc++;
        if (dacdav && !dav_q) begin
            dav_rises++;
            prev_rise = last_rise;
            last_rise = cyc;
        end
        dav_q = dacdav;
        if (bit_req) bitreq_cnt++;
        davdac = 1'b0;
        if (!dacdav) begin
            dcnt = 0;
        end else begin
            dcnt++;
            if (dac_on && dcnt == dac_delay) davdac = 1'b1;
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_sine_clk_en"}, 32'(sine_clk_en), 0);
        chk({tag, "_mod_en"}, 32'(mod_en), 0);
        chk({tag, "_en_awgn"}, 32'(en_awgn), 0);
        chk({tag, "_awgn_nrst"}, 32'(awgn_nrst), 0);
        chk({tag, "_dacdav"}, 32'(dacdav), 0);
        chk({tag, "_dacdata"}, 32'(dacdata), 0);
        chk({tag, "_bit_req"}, 32'(bit_req), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_overrun"}, 32'(overrun), 0);
        chk({tag, "_timeout_err"}, 32'(timeout_err), 0);
    endtask

    task automatic wait_rises(input int n, input int limit, input string tag);
        int c = 0;
        while (dav_rises < n && c < limit) begin
            step();
            c++;
        end
        chk(tag, 32'(dav_rises), 32'(n));
    endtask

    task automatic next_sample(input logic [16:0] v, input logic [15:0] exp, input string tag);
        int r = dav_rises;
        sample_in = v;
        wait_rises(r + 1, 100, {tag, "_arrive"});
        chk({tag, "_data"}, 32'(dacdata), 32'(exp));
        chk({tag, "_period"}, 32'(last_rise - prev_rise), 25);
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        int c;
        int b_rise;
        int b_req;
        rst = 1'b1;
        start = 1'b0;
        sine_rdy = 1'b1;
        sample_in = 17'd1000;
        repeat (3) step();
        chk_reset("reset");

        // Basic sequence and first-sample latency
        rst = 1'b0;
        start = 1'b1;
        b_rise = dav_rises;
        b_req = bitreq_cnt;
        step();
        chk("start_mod_en", 32'(mod_en), 1);
        chk("start_busy", 32'(busy), 1);
        chk("start_awgn_nrst", 32'(awgn_nrst), 1);
        c = 0;
        while (!sine_clk_en && c < 100) begin
            step();
            c++;
        end
        chk("first_sine_latency", 32'(c), 26);
        step();
        chk("noise_pulse", 32'(en_awgn), 1);
        chk("sine_one_cycle", 32'(sine_clk_en), 0);
        step();
        step();
        chk("first_dacdav", 32'(dacdav), 1);
        chk("first_dacdata", 32'(dacdata), 32'h03E8);

`ifdef BPSK_SEQ_SAT_EN
        next_sample(17'h09C40, 16'h7FFF, "pos40000");
        next_sample(17'h163C0, 16'h8000, "neg40000");
`else
        next_sample(17'h09C40, 16'h9C40, "pos40000");
        next_sample(17'h163C0, 16'h63C0, "neg40000");
`endif
        next_sample(17'h1FFFB, 16'hFFFB, "neg5");
        next_sample(17'h07FFF, 16'h7FFF, "max_in_range");

        wait_rises(b_rise + 17, 600, "sym1_samples");
        chk("sym1_bit_req", 32'(bitreq_cnt - b_req), 1);
        wait_rises(b_rise + 33, 600, "sym2_samples");
        chk("sym2_bit_req", 32'(bitreq_cnt - b_req), 2);
        chk("basic_overrun", 32'(overrun), 0);
        chk("basic_timeout", 32'(timeout_err), 0);

        // Stop mid-symbol: finishes the symbol then idles
        pulse_reset();
        b_rise = dav_rises;
        b_req = bitreq_cnt;
        wait_rises(b_rise + 5, 300, "stop_first5");
        c = 0;
        while (dacdav && c < 50) begin
            step();
            c++;
        end
        start = 1'b0;
        c = 0;
        while (mod_en && c < 1000) begin
            step();
            c++;
        end
        chk("stop_total_samples", 32'(dav_rises - b_rise), 16);
        chk("stop_bit_req", 32'(bitreq_cnt - b_req), 1);
        chk("stop_mod_en", 32'(mod_en), 0);
        chk("stop_awgn_nrst", 32'(awgn_nrst), 0);
        repeat (60) step();
        chk("stop_stays_idle", 32'(dav_rises - b_rise), 16);

        // DAC stall: timeout after 255 cycles in DAC_WAIT
        pulse_reset();
        dac_on = 1'b0;
        start = 1'b1;
        b_rise = dav_rises;
        wait_rises(b_rise + 1, 100, "stall_arrive");
        c = 0;
        while (dacdav && c < 400) begin
            step();
            c++;
        end
        chk("stall_wait_cycles", 32'(c), 255);
        chk("stall_timeout_err", 32'(timeout_err), 1);
        chk("stall_idle_mod_en", 32'(mod_en), 0);
        chk("stall_dacdav", 32'(dacdav), 0);
        start = 1'b0;
        repeat (5) step();
        chk("stall_sticky", 32'(timeout_err), 1);
        dac_on = 1'b1;

        // Slow DAC: overrun sets, sequencing continues
        pulse_reset();
        step();
        chk("slow_timeout_cleared", 32'(timeout_err), 0);
        dac_delay = 30;
        start = 1'b1;
        c = 0;
        while (!overrun && c < 1000) begin
            step();
            c++;
        end
        chk("slow_overrun", 32'(overrun), 1);
        b_rise = dav_rises;
        repeat (200) step();
        chk("slow_continues", 32'(dav_rises - b_rise >= 4), 1);
        chk("slow_overrun_sticky", 32'(overrun), 1);
        chk("slow_no_timeout", 32'(timeout_err), 0);

        // Reset during DAC_WAIT
        c = 0;
        while (!dacdav && c < 100) begin
            step();
            c++;
        end
        chk("midreset_in_dac_wait", 32'(dacdav), 1);
        rst = 1'b1;
        step();
        chk_reset("midreset");
        rst = 1'b0;
        start = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
